// File: rtl/apb_gpio_port.sv
// apb_gpio_port: APB-mapped GPIO port with output/enable registers,
// synchronised inputs, per-bit rise/fall edge events and a level IRQ.
//
// Build option: define GPIO_GLITCH_FILTER_EN to insert a per-bit glitch
// filter after the synchroniser. An input bit must then hold a new value for
// 4 consecutive cycles before it is accepted. Without the macro the
// synchroniser output is used directly and no filter logic is built.
//
// Register map (5-bit byte address, bits above WIDTH read 0):
//   0x00 IN       RO   filtered input
//   0x01 OUT      RW
//   0x02 OUT_SET  WO   OUT |= wdata, reads 0
//   0x03 OUT_CLR  WO   OUT &= ~wdata, reads 0
//   0x04 OE       RW   1 = drive
//   0x05 RISE_EN  RW
//   0x06 FALL_EN  RW
//   0x07 EVENT    R/W1C, a new edge wins over a simultaneous clear
//   0x08 IRQ_EN   RW
//   0x09..0x1F    read 0, writes ignored

module apb_gpio_port #(
  parameter int WIDTH       = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic             PCLK,
  input  logic             PRESET,
  input  logic             PSEL,
  input  logic [4:0]       PADDR,
  input  logic             PENABLE,
  input  logic             PWRITE,
  input  logic [7:0]       PWDATA,
  output logic [7:0]       PRDATA,
  output logic             PREADY,
  input  logic [WIDTH-1:0] GPIO_IN,
  output logic [WIDTH-1:0] GPIO_OUT,
  output logic [WIDTH-1:0] GPIO_OE,
  output logic             IRQ
);

  localparam logic [4:0] ADDR_IN      = 5'h00;
  localparam logic [4:0] ADDR_OUT     = 5'h01;
  localparam logic [4:0] ADDR_OUT_SET = 5'h02;
  localparam logic [4:0] ADDR_OUT_CLR = 5'h03;
  localparam logic [4:0] ADDR_OE      = 5'h04;
  localparam logic [4:0] ADDR_RISE_EN = 5'h05;
  localparam logic [4:0] ADDR_FALL_EN = 5'h06;
  localparam logic [4:0] ADDR_EVENT   = 5'h07;
  localparam logic [4:0] ADDR_IRQ_EN  = 5'h08;

`ifdef GPIO_GLITCH_FILTER_EN
  localparam int FILT_DELAY = 4;
`else
  localparam int FILT_DELAY = 0;
`endif

  // Cycles after reset release until "filtered" carries real pad data.
  localparam int         VALID_LAT = SYNC_STAGES + FILT_DELAY;
  localparam logic [3:0] VCNT_MAX  = 4'(VALID_LAT);

  logic [WIDTH-1:0] sync_q [SYNC_STAGES];
  logic [WIDTH-1:0] synced;
  logic [WIDTH-1:0] filtered;
  logic [WIDTH-1:0] prev_q;
  logic [3:0]       vcnt_q;
  logic             filtered_valid;
  logic             primed_q;

  logic [WIDTH-1:0] out_q;
  logic [WIDTH-1:0] oe_q;
  logic [WIDTH-1:0] rise_en_q;
  logic [WIDTH-1:0] fall_en_q;
  logic [WIDTH-1:0] event_q;
  logic [WIDTH-1:0] irq_en_q;

  logic             wr_en;
  logic [WIDTH-1:0] wdata;
  logic [WIDTH-1:0] evt_set;
  logic [WIDTH-1:0] evt_clr;
  logic [WIDTH-1:0] rd_val;
  logic             unused_pwdata;

  assign wr_en  = PSEL & PENABLE & PWRITE;
  assign wdata  = PWDATA[WIDTH-1:0];
  assign PREADY = 1'b1;

  // Upper write-data bits are meaningless when WIDTH < 8.
  assign unused_pwdata = ^PWDATA;

  // Metastability chain on the asynchronous pad inputs.
  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      for (int s = 0; s < SYNC_STAGES; s++) sync_q[s] <= '0;
    end else begin
      sync_q[0] <= GPIO_IN;
      for (int s = 1; s < SYNC_STAGES; s++) sync_q[s] <= sync_q[s-1];
    end
  end

  assign synced = sync_q[SYNC_STAGES-1];

`ifdef GPIO_GLITCH_FILTER_EN
  logic [WIDTH-1:0] filt_q;
  logic [1:0]       filt_cnt_q [WIDTH];

  // Accept a new input level only after 4 consecutive disagreeing samples.
  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      filt_q <= '0;
      for (int i = 0; i < WIDTH; i++) filt_cnt_q[i] <= 2'd0;
    end else begin
      for (int i = 0; i < WIDTH; i++) begin
        if (synced[i] == filt_q[i]) begin
          filt_cnt_q[i] <= 2'd0;
        end else if (filt_cnt_q[i] == 2'd3) begin
          filt_q[i]     <= synced[i];
          filt_cnt_q[i] <= 2'd0;
        end else begin
          filt_cnt_q[i] <= filt_cnt_q[i] + 2'd1;
        end
      end
    end
  end

  assign filtered = filt_q;
`else
  assign filtered = synced;
`endif

  // Counts reset-release cycles until the input pipeline has flushed.
  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      vcnt_q <= 4'd0;
    end else if (!filtered_valid) begin
      vcnt_q <= vcnt_q + 4'd1;
    end
  end

  assign filtered_valid = (vcnt_q == VCNT_MAX);

  // primed rises one cycle after filtered becomes valid, so prev is also
  // valid before any edge is compared; pre-reset history never leaks through.
  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      primed_q <= 1'b0;
    end else if (filtered_valid) begin
      primed_q <= 1'b1;
    end
  end

  // Previous filtered value for edge comparison.
  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      prev_q <= '0;
    end else begin
      prev_q <= filtered;
    end
  end

  assign evt_set = primed_q ? ((filtered & ~prev_q & rise_en_q) |
                               (~filtered & prev_q & fall_en_q)) : '0;
  assign evt_clr = (wr_en && (PADDR == ADDR_EVENT)) ? wdata : '0;

  // Configuration and output register writes; reset wins over a write.
  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      out_q     <= '0;
      oe_q      <= '0;
      rise_en_q <= '0;
      fall_en_q <= '0;
      irq_en_q  <= '0;
    end else if (wr_en) begin
      case (PADDR)
        ADDR_OUT:     out_q     <= wdata;
        ADDR_OUT_SET: out_q     <= out_q | wdata;
        ADDR_OUT_CLR: out_q     <= out_q & ~wdata;
        ADDR_OE:      oe_q      <= wdata;
        ADDR_RISE_EN: rise_en_q <= wdata;
        ADDR_FALL_EN: fall_en_q <= wdata;
        ADDR_IRQ_EN:  irq_en_q  <= wdata;
        default: ;
      endcase
    end
  end

  // Sticky edge events: clear first, then set, so a new edge survives a W1C.
  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      event_q <= '0;
    end else begin
      event_q <= (event_q & ~evt_clr) | evt_set;
    end
  end

  // Combinational read mux, decoded from PADDR alone.
  always_comb begin
    rd_val = '0;
    case (PADDR)
      ADDR_IN:      rd_val = filtered;
      ADDR_OUT:     rd_val = out_q;
      ADDR_OE:      rd_val = oe_q;
      ADDR_RISE_EN: rd_val = rise_en_q;
      ADDR_FALL_EN: rd_val = fall_en_q;
      ADDR_EVENT:   rd_val = event_q;
      ADDR_IRQ_EN:  rd_val = irq_en_q;
      default:      rd_val = '0;
    endcase
    PRDATA = 8'h00;
    PRDATA[WIDTH-1:0] = rd_val;
  end

  assign GPIO_OUT = out_q;
  assign GPIO_OE  = oe_q;
  assign IRQ      = |(event_q & irq_en_q);

endmodule

// File: tb/tb_apb_gpio_port.sv
// Bench for apb_gpio_port: register table vectors, hand-built latency and
// edge/clear corner sequences, then random traffic checked cycle by cycle
// against a delay-line model of the port. A second WIDTH=4 instance checks
// narrow-register masking.

module tb_apb_gpio_port;

  localparam int W = 8;
  localparam int S = 2;
`ifdef GPIO_GLITCH_FILTER_EN
  localparam int FD = 4;
`else
  localparam int FD = 0;
`endif
  localparam int LAT = S + FD;
  localparam logic [7:0] MASK = 8'hFF;

  logic       PCLK = 1'b0;
  logic       PRESET, PSEL, PENABLE, PWRITE, PREADY, IRQ;
  logic [4:0] PADDR;
  logic [7:0] PWDATA, PRDATA;
  logic [7:0] GPIO_IN, GPIO_OUT, GPIO_OE;

  logic       PSEL4, PREADY4, IRQ4;
  logic [7:0] PRDATA4;
  logic [3:0] GPIO_IN4, GPIO_OUT4, GPIO_OE4;

  always #5 PCLK = ~PCLK;

  apb_gpio_port #(.WIDTH(W), .SYNC_STAGES(S)) dut (
    .PCLK(PCLK), .PRESET(PRESET), .PSEL(PSEL), .PADDR(PADDR),
    .PENABLE(PENABLE), .PWRITE(PWRITE), .PWDATA(PWDATA),
    .PRDATA(PRDATA), .PREADY(PREADY), .GPIO_IN(GPIO_IN),
    .GPIO_OUT(GPIO_OUT), .GPIO_OE(GPIO_OE), .IRQ(IRQ)
  );

  apb_gpio_port #(.WIDTH(4), .SYNC_STAGES(S)) dut4 (
    .PCLK(PCLK), .PRESET(PRESET), .PSEL(PSEL4), .PADDR(PADDR),
    .PENABLE(PENABLE), .PWRITE(PWRITE), .PWDATA(PWDATA),
    .PRDATA(PRDATA4), .PREADY(PREADY4), .GPIO_IN(GPIO_IN4),
    .GPIO_OUT(GPIO_OUT4), .GPIO_OE(GPIO_OE4), .IRQ(IRQ4)
  );

  int n_chk = 0;
  int n_err = 0;

  // ---------------- reference model ----------------
  logic [7:0] m_out, m_oe, m_rise, m_fall, m_evt, m_ien;
  logic [7:0] hist[$];   // pad sample taken at each edge since reset
  logic [7:0] fq[$];     // fq[n] = filtered value after edge n (fq[0] = reset)
  int         n_edge;

  function automatic logic [7:0] synced_at(int m);
    if (m >= S && (m - S) < hist.size()) return hist[m-S];
    return 8'h00;
  endfunction

  function automatic logic [7:0] m_read(logic [4:0] a);
    case (a)
      5'h00: return fq[n_edge];
      5'h01: return m_out;
      5'h04: return m_oe;
      5'h05: return m_rise;
      5'h06: return m_fall;
      5'h07: return m_evt;
      5'h08: return m_ien;
      default: return 8'h00;
    endcase
  endfunction

  task automatic model_reset();
    m_out = 0; m_oe = 0; m_rise = 0; m_fall = 0; m_evt = 0; m_ien = 0;
    hist.delete(); fq.delete(); fq.push_back(8'h00); n_edge = 0;
  endtask

  // Advance the model across one rising edge using the inputs now applied.
  task automatic model_step();
    logic [7:0] wd, fp, fnew, set, clr, f1, f2;
    bit wr;
    if (PRESET) begin
      model_reset();
      return;
    end
    wr = PSEL && PENABLE && PWRITE;
    wd = PWDATA & MASK;
    n_edge++;
    hist.push_back(GPIO_IN & MASK);
    fp = fq[n_edge-1];
`ifdef GPIO_GLITCH_FILTER_EN
    begin
      logic [7:0] s1, s2, s3, s4, same, chg;
      s1 = synced_at(n_edge-1); s2 = synced_at(n_edge-2);
      s3 = synced_at(n_edge-3); s4 = synced_at(n_edge-4);
      same = ~(s1 ^ s2) & ~(s2 ^ s3) & ~(s3 ^ s4);
      chg  = same & (s1 ^ fp);
      fnew = (fp & ~chg) | (s1 & chg);
    end
`else
    fnew = synced_at(n_edge);
`endif
    fq.push_back(fnew);
    set = 8'h00;
    if (n_edge >= LAT + 2) begin
      f1 = fq[n_edge-1];
      f2 = fq[n_edge-2];
      set = (f1 & ~f2 & m_rise) | (~f1 & f2 & m_fall);
    end
    clr = (wr && PADDR == 5'h07) ? wd : 8'h00;
    if (wr) begin
      case (PADDR)
        5'h01: m_out  = wd;
        5'h02: m_out  = m_out | wd;
        5'h03: m_out  = m_out & ~wd;
        5'h04: m_oe   = wd;
        5'h05: m_rise = wd;
        5'h06: m_fall = wd;
        5'h08: m_ien  = wd;
        default: ;
      endcase
    end
    m_evt = (m_evt & ~clr) | set;
  endtask

  // ---------------- check helpers ----------------
  task automatic chk(string name, logic [7:0] act, logic [7:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %02h expected %02h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock: update model, pass the edge, compare every output to model.
  task automatic cycle();
    model_step();
    @(posedge PCLK);
    #1;
    chk("pready",   {7'b0, PREADY}, 8'h01);
    chk("gpio_out", GPIO_OUT, m_out);
    chk("gpio_oe",  GPIO_OE,  m_oe);
    chk("irq",      {7'b0, IRQ}, {7'b0, |(m_evt & m_ien)});
    chk("prdata",   PRDATA, m_read(PADDR));
  endtask

  task automatic idle(int k);
    for (int i = 0; i < k; i++) cycle();
  endtask

  task automatic bus_idle();
    PSEL = 0; PENABLE = 0; PWRITE = 0;
  endtask

  task automatic apb_write(logic [4:0] a, logic [7:0] d);
    PSEL = 1; PWRITE = 1; PENABLE = 0; PADDR = a; PWDATA = d;
    cycle();
    PENABLE = 1;
    cycle();
    bus_idle();
  endtask

  // Single-cycle access phase so the commit lands on a chosen edge.
  task automatic quick_write(logic [4:0] a, logic [7:0] d);
    PSEL = 1; PWRITE = 1; PENABLE = 1; PADDR = a; PWDATA = d;
    cycle();
    bus_idle();
  endtask

  task automatic rd_chk(string name, logic [4:0] a, logic [7:0] exp);
    PADDR = a;
    #1;
    chk(name, PRDATA, exp);
  endtask

  task automatic do_reset();
    PRESET = 1;
    cycle();
    cycle();
    PRESET = 0;
  endtask

  typedef struct {
    logic [4:0] waddr;
    logic [7:0] wdata;
    logic [4:0] raddr;
    logic [7:0] rexp;
    logic [7:0] oexp;
  } vec_t;

  vec_t vt[12];

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    bit seen;

    vt[0]  = '{5'h01, 8'hA5, 5'h01, 8'hA5, 8'hA5};
    vt[1]  = '{5'h02, 8'h0A, 5'h01, 8'hAF, 8'hAF};
    vt[2]  = '{5'h03, 8'h21, 5'h01, (8'hA5 | 8'h0A) & ~8'h21, 8'h8E};
    vt[3]  = '{5'h00, 8'hFF, 5'h02, 8'h00, 8'h8E};
    vt[4]  = '{5'h04, 8'h3C, 5'h03, 8'h00, 8'h8E};
    vt[5]  = '{5'h1F, 8'h55, 5'h04, 8'h3C, 8'h8E};
    vt[6]  = '{5'h08, 8'h81, 5'h08, 8'h81, 8'h8E};
    vt[7]  = '{5'h09, 8'h77, 5'h09, 8'h00, 8'h8E};
    vt[8]  = '{5'h05, 8'h5A, 5'h05, 8'h5A, 8'h8E};
    vt[9]  = '{5'h06, 8'hC3, 5'h06, 8'hC3, 8'h8E};
    vt[10] = '{5'h01, 8'h00, 5'h00, 8'h00, 8'h00};
    vt[11] = '{5'h07, 8'hFF, 5'h07, 8'h00, 8'h00};

    model_reset();
    PRESET = 1; PSEL = 0; PENABLE = 0; PWRITE = 0; PADDR = 0; PWDATA = 0;
    GPIO_IN = 8'hFF; PSEL4 = 0; GPIO_IN4 = 4'h0;
    #1;

    // Reset values, with pads high throughout reset.
    do_reset();
    chk("rst_gpio_out", GPIO_OUT, 8'h00);
    chk("rst_gpio_oe",  GPIO_OE,  8'h00);
    chk("rst_irq",      {7'b0, IRQ}, 8'h00);
    chk("rst_pready",   {7'b0, PREADY}, 8'h01);
    rd_chk("rst_event", 5'h07, 8'h00);

    // Pads held high through reset must not create rise events.
    apb_write(5'h05, 8'hFF);
    idle(LAT + 6);
    rd_chk("evt_held_through_rst", 5'h07, 8'h00);

    // Reset while a real 0->1 transition is in flight.
    GPIO_IN = 8'h00;
    idle(LAT + 3);
    GPIO_IN = 8'hFF;
    cycle();
    do_reset();
    apb_write(5'h05, 8'hFF);
    idle(LAT + 6);
    rd_chk("evt_mid_op_rst", 5'h07, 8'h00);

    // Register table.
    GPIO_IN = 8'h00;
    do_reset();
    idle(LAT + 3);
    for (int i = 0; i < 12; i++) begin
      apb_write(vt[i].waddr, vt[i].wdata);
      rd_chk($sformatf("vec%0d_rd", i), vt[i].raddr, vt[i].rexp);
      chk($sformatf("vec%0d_out", i), GPIO_OUT, vt[i].oexp);
    end

    // Rise latency on bit 0 and IRQ clear.
    do_reset();
    idle(LAT + 3);
    apb_write(5'h05, 8'h01);
    apb_write(5'h08, 8'h01);
    PADDR = 5'h00;
    GPIO_IN = 8'h01;
    for (int d = 0; d <= LAT; d++) begin
      cycle();
      chk($sformatf("lat_in0_d%0d", d), {7'b0, PRDATA[0]}, {7'b0, 1'(d >= LAT - 1)});
      chk($sformatf("lat_irq_d%0d", d), {7'b0, IRQ}, {7'b0, 1'(d >= LAT)});
    end
    rd_chk("lat_event", 5'h07, 8'h01);
    quick_write(5'h07, 8'h01);
    chk("lat_irq_cleared", {7'b0, IRQ}, 8'h00);
    rd_chk("lat_event_cleared", 5'h07, 8'h00);

    // New falling edge on bit 3 coinciding with a W1C of EVENT[3].
    GPIO_IN = 8'h08;
    do_reset();
    idle(LAT + 3);
    apb_write(5'h06, 8'h08);
    GPIO_IN = 8'h00;
    idle(LAT + 1);
    rd_chk("fall_first", 5'h07, 8'h08);
    GPIO_IN = 8'h08;
    idle(LAT + 2);
    GPIO_IN = 8'h00;
    idle(LAT);
    quick_write(5'h07, 8'h08);
    rd_chk("fall_w1c_collide", 5'h07, 8'h08);
    quick_write(5'h07, 8'h08);
    rd_chk("fall_w1c_alone", 5'h07, 8'h00);

`ifdef GPIO_GLITCH_FILTER_EN
    // Glitch filter: 3-cycle pulse rejected, 4-cycle pulse accepted.
    do_reset();
    idle(LAT + 3);
    apb_write(5'h05, 8'h04);
    PADDR = 5'h00;
    GPIO_IN = 8'h04;
    idle(3);
    GPIO_IN = 8'h00;
    seen = 0;
    for (int i = 0; i < 12; i++) begin
      cycle();
      if (PRDATA[2]) seen = 1;
    end
    chk("flt3_in_seen", {7'b0, seen}, 8'h00);
    rd_chk("flt3_event", 5'h07, 8'h00);
    PADDR = 5'h00;
    GPIO_IN = 8'h04;
    cycle();
    if (PRDATA[2]) seen = 1;
    idle(3);
    GPIO_IN = 8'h00;
    for (int i = 0; i < 14; i++) begin
      cycle();
      if (PRDATA[2]) seen = 1;
    end
    chk("flt4_in_seen", {7'b0, seen}, 8'h01);
    rd_chk("flt4_event", 5'h07, 8'h04);
`endif

    // Random traffic against the model.
    do_reset();
    for (int i = 0; i < 900; i++) begin
      PRESET  = ($urandom_range(0, 199) == 0);
      PSEL    = $urandom_range(0, 1) == 1;
      PENABLE = $urandom_range(0, 1) == 1;
      PWRITE  = $urandom_range(0, 2) != 0;
      PADDR   = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31))
                                            : 5'($urandom_range(0, 8));
      PWDATA  = 8'($urandom);
      if ($urandom_range(0, 5) == 0) GPIO_IN = GPIO_IN ^ 8'($urandom);
      cycle();
    end
    PRESET = 0;
    bus_idle();

    // Narrow instance: upper register bits read 0.
    do_reset();
    PSEL4 = 1; PWRITE = 1; PENABLE = 1; PADDR = 5'h04; PWDATA = 8'hFF;
    cycle();
    PSEL4 = 0;
    bus_idle();
    chk("w4_gpio_oe", {4'h0, GPIO_OE4}, 8'h0F);
    PADDR = 5'h04;
    #1;
    chk("w4_oe_read", PRDATA4, 8'h0F);
    PADDR = 5'h0C;
    #1;
    chk("w4_unmapped_read", PRDATA4, 8'h00);
    chk("w4_pready", {7'b0, PREADY4}, 8'h01);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
